// File: rtl/note_osc_if.sv
// Bus between the octave-divisor/keyboard stage and the note oscillator bank.
// The master side supplies divisors and keys; the slave side produces waves and samples.
interface note_osc_if #(
   parameter int DIV_W = 18,
   parameter int MIX_W = 4
);
   logic [DIV_W-1:0] div0;
   logic [DIV_W-1:0] div1;
   logic [DIV_W-1:0] div2;
   logic [DIV_W-1:0] div3;
   logic [DIV_W-1:0] div4;
   logic [DIV_W-1:0] div5;
   logic [DIV_W-1:0] div6;
   logic [DIV_W-1:0] div7;
   logic [DIV_W-1:0] div8;
   logic [DIV_W-1:0] div9;
   logic [DIV_W-1:0] div10;
   logic [DIV_W-1:0] div11;
   logic [11:0]      keys;
   logic [11:0]      wave;
   logic [MIX_W-1:0] mix;
   logic [MIX_W-1:0] sample;
   logic             sample_valid;

   modport master (
      output div0, div1, div2, div3, div4, div5,
      output div6, div7, div8, div9, div10, div11,
      output keys,
      input  wave, mix, sample, sample_valid
   );

   modport slave (
      input  div0, div1, div2, div3, div4, div5,
      input  div6, div7, div8, div9, div10, div11,
      input  keys,
      output wave, mix, sample, sample_valid
   );
endinterface

// File: rtl/note_oscillator_bank.sv
// Twelve keyed half-period square-wave voices, a registered voice-count mix,
// and a periodic sample strobe feeding the DAC/PWM stage.
module note_oscillator_bank #(
   parameter int DIV_W      = 18,
   parameter int SAMPLE_DIV = 256,
   parameter int MIX_W      = 4
) (
   input  logic       clk,
   input  logic       rst,
   note_osc_if.slave  bus
);
   localparam int                 NV        = 12;
   localparam int                 SCNT_W    = $clog2(SAMPLE_DIV);
   localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(SAMPLE_DIV - 1);
   localparam logic [SCNT_W-1:0]  SCNT_ONE  = SCNT_W'(1);
   localparam logic [DIV_W-1:0]   DIV_ZERO  = DIV_W'(0);
   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);

   logic [DIV_W-1:0]  div_s      [NV];
   logic [DIV_W-1:0]  cnt_r      [NV];
   logic [DIV_W-1:0]  cnt_nxt_s  [NV];
   logic [NV-1:0]     active_s;
   logic [NV-1:0]     wave_r;
   logic [NV-1:0]     wave_nxt_s;
   logic [MIX_W-1:0]  mix_r;
   logic [MIX_W-1:0]  sample_r;
   logic              sample_valid_r;
   logic [SCNT_W-1:0] scnt_r;

   function automatic logic [MIX_W-1:0] popcount12(input logic [NV-1:0] v);
      logic [MIX_W-1:0] acc;
      acc = {MIX_W{1'b0}};
      for (int i = 0; i < NV; i++) begin
         acc = acc + {{(MIX_W-1){1'b0}}, v[i]};
      end
      return acc;
   endfunction

   // Gather the per-note divisors into an indexable array.
   always_comb begin
      div_s[0]  = bus.div0;
      div_s[1]  = bus.div1;
      div_s[2]  = bus.div2;
      div_s[3]  = bus.div3;
      div_s[4]  = bus.div4;
      div_s[5]  = bus.div5;
      div_s[6]  = bus.div6;
      div_s[7]  = bus.div7;
      div_s[8]  = bus.div8;
      div_s[9]  = bus.div9;
      div_s[10] = bus.div10;
      div_s[11] = bus.div11;
   end

   // Per-voice next state; the >= compare lets a shrunken divisor wrap at once.
   always_comb begin
      active_s   = {NV{1'b0}};
      wave_nxt_s = wave_r;
      for (int i = 0; i < NV; i++) begin
         cnt_nxt_s[i] = cnt_r[i];
         active_s[i]  = bus.keys[i] && (div_s[i] != DIV_ZERO);
         if (!active_s[i]) begin
            cnt_nxt_s[i]  = DIV_ZERO;
            wave_nxt_s[i] = 1'b0;
         end else if (cnt_r[i] >= (div_s[i] - DIV_ONE)) begin
            cnt_nxt_s[i]  = DIV_ZERO;
            wave_nxt_s[i] = ~wave_r[i];
         end else begin
            cnt_nxt_s[i]  = cnt_r[i] + DIV_ONE;
            wave_nxt_s[i] = wave_r[i];
         end
      end
   end

   // Voice counter and wave registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NV; i++) begin
            cnt_r[i] <= DIV_ZERO;
         end
         wave_r <= {NV{1'b0}};
      end else begin
         for (int i = 0; i < NV; i++) begin
            cnt_r[i] <= cnt_nxt_s[i];
         end
         wave_r <= wave_nxt_s;
      end
   end

   // Mix counts the registered waves, so it trails them by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         mix_r <= {MIX_W{1'b0}};
      end else begin
         mix_r <= popcount12(wave_r);
      end
   end

   // Sample strobe: latch the mix once every SAMPLE_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt_r         <= {SCNT_W{1'b0}};
         sample_r       <= {MIX_W{1'b0}};
         sample_valid_r <= 1'b0;
      end else if (scnt_r == SCNT_LAST) begin
         scnt_r         <= {SCNT_W{1'b0}};
         sample_r       <= mix_r;
         sample_valid_r <= 1'b1;
      end else begin
         scnt_r         <= scnt_r + SCNT_ONE;
         sample_r       <= sample_r;
         sample_valid_r <= 1'b0;
      end
   end

   assign bus.wave         = wave_r;
   assign bus.mix          = mix_r;
   assign bus.sample       = sample_r;
   assign bus.sample_valid = sample_valid_r;

endmodule

// File: tb/tb_note_oscillator_bank.sv
// Scoreboard bench: stimulus queues edge-tagged expectations, a negedge monitor
// pops and compares them against the oscillator bank outputs.
module tb_note_oscillator_bank;
   localparam int K_WAVE = 0;
   localparam int K_MIX  = 1;
   localparam int K_SV   = 2;
   localparam int K_SMP  = 3;

   typedef struct {
      int          cyc;
      int          kind;
      int          ph;
      logic [11:0] val;
   } exp_t;

   logic clk;
   logic rst;
   int   edge_n   = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t it;
   logic [11:0] act;

   note_osc_if #(.DIV_W(18), .MIX_W(4)) bus();

   note_oscillator_bank #(.DIV_W(18), .SAMPLE_DIV(8), .MIX_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Monitor: compare every expectation tagged with the edge just taken.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
         it = sb.pop_front();
         case (it.kind)
            K_WAVE:  act = bus.wave;
            K_MIX:   act = {8'd0, bus.mix};
            K_SV:    act = {11'd0, bus.sample_valid};
            default: act = {8'd0, bus.sample};
         endcase
         n_checks++;
         if (it.cyc != edge_n || act !== it.val) begin
            n_errors++;
            $display("FAIL kind%0d ph%0d edge %0d (tag %0d): got %h expected %h",
                     it.kind, it.ph, edge_n, it.cyc, act, it.val);
         end
      end
   end

   task automatic push(input int cyc, input int kind, input int ph, input logic [11:0] val);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.ph = ph; e.val = val;
      sb.push_back(e);
   endtask

   task automatic advance(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_all_div(input logic [17:0] d);
      bus.div0 = d; bus.div1 = d; bus.div2 = d;  bus.div3 = d;
      bus.div4 = d; bus.div5 = d; bus.div6 = d;  bus.div7 = d;
      bus.div8 = d; bus.div9 = d; bus.div10 = d; bus.div11 = d;
   endtask

   task automatic push_reset_state(input int cyc, input int ph);
      push(cyc, K_WAVE, ph, 12'h000);
      push(cyc, K_MIX,  ph, 12'h000);
      push(cyc, K_SV,   ph, 12'h000);
      push(cyc, K_SMP,  ph, 12'h000);
   endtask

   initial begin : stim
      int b;
      logic [11:0] w_tab [12];
      logic [11:0] m_tab [13];
      w_tab = '{12'h000, 12'h001, 12'h003, 12'h002, 12'h002, 12'h001,
                12'h001, 12'h000, 12'h002, 12'h003, 12'h003, 12'h000};
      m_tab = '{12'd0, 12'd0, 12'd1, 12'd2, 12'd1, 12'd1, 12'd1,
                12'd1, 12'd0, 12'd1, 12'd2, 12'd2, 12'd0};

      // Phase 0: reset held two edges with everything keyed.
      rst = 1'b1;
      bus.keys = 12'hFFF;
      set_all_div(18'd4);
      push_reset_state(1, 0);
      push_reset_state(2, 0);
      advance(2);

      // Phase 1: single voice, div0=4, five-plus periods.
      rst = 1'b0;
      bus.keys = 12'h001;
      b = edge_n;
      for (int k = 1; k <= 44; k++) begin
         push(b + k, K_WAVE, 1, ((k / 4) % 2 == 1) ? 12'h001 : 12'h000);
         push(b + k, K_MIX,  1, (((k - 1) / 4) % 2 == 1) ? 12'd1 : 12'd0);
      end
      advance(44);

      // Phase 2: release while high, then re-press.
      bus.keys = 12'h000;
      b = edge_n;
      push(b + 1, K_WAVE, 2, 12'h000);
      push(b + 1, K_MIX,  2, 12'd1);
      push(b + 2, K_WAVE, 2, 12'h000);
      push(b + 2, K_MIX,  2, 12'd0);
      advance(2);
      bus.keys = 12'h001;
      b = edge_n;
      for (int k = 1; k <= 8; k++) begin
         push(b + k, K_WAVE, 2, (k >= 4 && k <= 7) ? 12'h001 : 12'h000);
      end
      advance(8);

      // Phase 3: all twelve voices at div=3.
      bus.keys = 12'h000;
      advance(2);
      bus.keys = 12'hFFF;
      set_all_div(18'd3);
      b = edge_n;
      for (int k = 1; k <= 18; k++) begin
         push(b + k, K_WAVE, 3, ((k / 3) % 2 == 1) ? 12'hFFF : 12'h000);
         push(b + k, K_MIX,  3, (((k - 1) / 3) % 2 == 1) ? 12'd12 : 12'd0);
      end
      advance(18);

      // Phase 4: div0=2, div1=3, voice 5 keyed but silent.
      bus.keys = 12'h000;
      advance(2);
      bus.keys = 12'h023;
      bus.div0 = 18'd2;
      bus.div1 = 18'd3;
      bus.div5 = 18'd0;
      b = edge_n;
      for (int k = 1; k <= 13; k++) begin
         if (k <= 12) push(b + k, K_WAVE, 4, w_tab[k-1]);
         push(b + k, K_MIX, 4, m_tab[k-1]);
      end
      advance(13);

      // Phase 5: shrink div0 from 100 to 10 mid-count.
      bus.keys = 12'h000;
      advance(2);
      bus.keys = 12'h001;
      bus.div0 = 18'd100;
      b = edge_n;
      push(b + 1,  K_WAVE, 5, 12'h000);
      push(b + 50, K_WAVE, 5, 12'h000);
      advance(50);
      bus.div0 = 18'd10;
      b = edge_n;
      for (int j = 1; j <= 22; j++) begin
         push(b + j, K_WAVE, 5, (j <= 10 || j >= 21) ? 12'h001 : 12'h000);
      end
      advance(22);

      // Phase 6: sampling after a reset, div=1 on three voices.
      rst = 1'b1;
      bus.keys = 12'h007;
      set_all_div(18'd1);
      push_reset_state(edge_n + 1, 6);
      advance(1);
      rst = 1'b0;
      b = edge_n;
      for (int k = 1; k <= 26; k++) begin
         push(b + k, K_WAVE, 6, (k % 2 == 1) ? 12'h007 : 12'h000);
         push(b + k, K_MIX,  6, (k % 2 == 0) ? 12'd3 : 12'd0);
         push(b + k, K_SV,   6, (k % 8 == 0) ? 12'd1 : 12'd0);
         push(b + k, K_SMP,  6, 12'd0);
      end
      advance(26);

      // Phase 7: reset mid-count restarts spacing; div=2 gives a nonzero sample.
      rst = 1'b1;
      bus.div0 = 18'd2;
      bus.div1 = 18'd2;
      bus.div2 = 18'd2;
      push_reset_state(edge_n + 1, 7);
      advance(1);
      rst = 1'b0;
      b = edge_n;
      for (int k = 1; k <= 17; k++) begin
         push(b + k, K_WAVE, 7, ((k / 2) % 2 == 1) ? 12'h007 : 12'h000);
         push(b + k, K_MIX,  7, (((k - 1) / 2) % 2 == 1) ? 12'd3 : 12'd0);
         push(b + k, K_SV,   7, (k == 8 || k == 16) ? 12'd1 : 12'd0);
         push(b + k, K_SMP,  7, (k >= 8) ? 12'd3 : 12'd0);
      end
      advance(17);

      advance(2);
      n_checks++;
      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
